// File: rtl/fp_align_unit.sv
// Operand-alignment stage for a binary32 add/sub core: orders the operands by magnitude, flags NaN/Inf,
// and right-shifts the smaller significand STEP bits per cycle while keeping guard/round/sticky bits.
module fp_align_unit #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        checkequation,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign_big,
  output logic        out_sign_small,
  output logic [7:0]  out_exp,
  output logic [23:0] out_mant_big,
  output logic [26:0] out_mant_small,
  output logic        out_swap,
  output logic        out_nan,
  output logic        out_inf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [4:0] STEP_K   = 5'(STEP);
  localparam logic [7:0] MAX_SHFT = 8'd27;

  state_t      state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic        sign_big_q, sign_big_d;
  logic        sign_small_q, sign_small_d;
  logic [7:0]  exp_q, exp_d;
  logic [23:0] mant_big_q, mant_big_d;
  logic [26:0] mant_small_q, mant_small_d;
  logic        swap_q, swap_d;
  logic        nan_q, nan_d;
  logic        inf_q, inf_d;
  logic [4:0]  rem_q, rem_d;

  // Operand decode, evaluated every cycle and consumed only on capture.
  logic [7:0]  a_exp, b_exp, a_eexp, b_eexp;
  logic        a_norm, b_norm;
  logic [23:0] a_mant, b_mant;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        b_sign_eff;
  logic        cap_swap, cap_nan, cap_inf;
  logic [7:0]  cap_exp_big, cap_exp_small, cap_diff;
  logic [4:0]  cap_shift;

  assign a_exp      = a[30:23];
  assign b_exp      = b[30:23];
  assign a_norm     = |a_exp;
  assign b_norm     = |b_exp;
  // Denormals and zero behave as exponent 1 with a clear hidden bit.
  assign a_eexp     = a_norm ? a_exp : 8'd1;
  assign b_eexp     = b_norm ? b_exp : 8'd1;
  assign a_mant     = {a_norm, a[22:0]};
  assign b_mant     = {b_norm, b[22:0]};
  assign a_nan      = (&a_exp) & (|a[22:0]);
  assign b_nan      = (&b_exp) & (|b[22:0]);
  assign a_inf      = (&a_exp) & ~(|a[22:0]);
  assign b_inf      = (&b_exp) & ~(|b[22:0]);
  assign b_sign_eff = b[31] ^ checkequation;

  assign cap_swap      = a[30:0] < b[30:0];
  assign cap_nan       = a_nan | b_nan | (a_inf & b_inf & (a[31] != b_sign_eff));
  assign cap_inf       = ~cap_nan & (a_inf | b_inf);
  assign cap_exp_big   = cap_swap ? b_eexp : a_eexp;
  assign cap_exp_small = cap_swap ? a_eexp : b_eexp;
  assign cap_diff      = cap_exp_big - cap_exp_small;
  assign cap_shift     = (cap_diff > MAX_SHFT) ? 5'd27 : cap_diff[4:0];

  // Per-cycle shift: k = min(STEP, remaining); every bit dropped folds into the sticky position.
  logic [4:0]  step_k;
  logic [26:0] lost_mask;
  logic [26:0] shifted;

  assign step_k    = (rem_q < STEP_K) ? rem_q : STEP_K;
  assign lost_mask = (27'd1 << step_k) - 27'd1;
  assign shifted   = mant_small_q >> step_k;

  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    exp_d        = exp_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;
    swap_d       = swap_q;
    nan_d        = nan_q;
    inf_d        = inf_q;
    rem_d        = rem_q;

    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          in_ready_d   = 1'b0;
          swap_d       = cap_swap;
          sign_big_d   = cap_swap ? b_sign_eff : a[31];
          sign_small_d = cap_swap ? a[31] : b_sign_eff;
          exp_d        = cap_exp_big;
          mant_big_d   = cap_swap ? b_mant : a_mant;
          mant_small_d = {(cap_swap ? a_mant : b_mant), 3'b000};
          nan_d        = cap_nan;
          inf_d        = cap_inf;
          rem_d        = cap_shift;
          if (cap_nan || cap_inf || (cap_shift == 5'd0)) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        mant_small_d = {shifted[26:1], shifted[0] | (|(mant_small_q & lost_mask))};
        rem_d        = rem_q - step_k;
        if (rem_q == step_k) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // out_valid rises one edge after entering DONE, giving latency 1 + ceil(d/STEP).
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      exp_q        <= 8'd0;
      mant_big_q   <= 24'd0;
      mant_small_q <= 27'd0;
      swap_q       <= 1'b0;
      nan_q        <= 1'b0;
      inf_q        <= 1'b0;
      rem_q        <= 5'd0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      exp_q        <= exp_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
      swap_q       <= swap_d;
      nan_q        <= nan_d;
      inf_q        <= inf_d;
      rem_q        <= rem_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_sign_big   = sign_big_q;
  assign out_sign_small = sign_small_q;
  assign out_exp        = exp_q;
  assign out_mant_big   = mant_big_q;
  assign out_mant_small = mant_small_q;
  assign out_swap       = swap_q;
  assign out_nan        = nan_q;
  assign out_inf        = inf_q;

endmodule

// File: tb/tb_fp_align_unit.sv
// Scoreboard bench for fp_align_unit: two instances (STEP=1 and STEP=4) see identical stimulus;
// each has its own expected-response queue drained by an independent output monitor.
module tb_fp_align_unit;

  typedef struct {
    logic        sb;
    logic        ss;
    logic [7:0]  e;
    logic [23:0] mb;
    logic [26:0] ms;
    logic        sw;
    logic        nan;
    logic        inf;
    logic        data;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        checkequation = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;

  logic        ir [2];
  logic        ov [2];
  logic        osb [2];
  logic        oss [2];
  logic [7:0]  oe [2];
  logic [23:0] omb [2];
  logic [26:0] oms [2];
  logic        osw [2];
  logic        onan [2];
  logic        oinf [2];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   cap0 = 0, cap1 = 0;
  bit   vis0 = 0, vis1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_align_unit #(.STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .checkequation(checkequation), .out_valid(ov[0]), .out_ready(out_ready),
    .out_sign_big(osb[0]), .out_sign_small(oss[0]), .out_exp(oe[0]), .out_mant_big(omb[0]),
    .out_mant_small(oms[0]), .out_swap(osw[0]), .out_nan(onan[0]), .out_inf(oinf[0])
  );

  fp_align_unit #(.STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .checkequation(checkequation), .out_valid(ov[1]), .out_ready(out_ready),
    .out_sign_big(osb[1]), .out_sign_small(oss[1]), .out_exp(oe[1]), .out_mant_big(omb[1]),
    .out_mant_small(oms[1]), .out_swap(osw[1]), .out_nan(onan[1]), .out_inf(oinf[1])
  );

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL dut%0d %s actual=0x%0h required=0x%0h (t=%0t)", id, name, act, req, $time);
    end
  endtask

  task automatic cmp_out(input int id, input exp_t e, input bit first, input int lat_act);
    if (first) chk(id, "latency", lat_act, e.lat);
    chk(id, "in_ready_low_in_done", 32'(ir[id]), 32'd0);
    chk(id, "nan", 32'(onan[id]), 32'(e.nan));
    chk(id, "inf", 32'(oinf[id]), 32'(e.inf));
    if (e.data) begin
      chk(id, "sign_big", 32'(osb[id]), 32'(e.sb));
      chk(id, "sign_small", 32'(oss[id]), 32'(e.ss));
      chk(id, "exp", 32'(oe[id]), 32'(e.e));
      chk(id, "mant_big", 32'(omb[id]), 32'(e.mb));
      chk(id, "mant_small", 32'(oms[id]), 32'(e.ms));
      chk(id, "swap", 32'(osw[id]), 32'(e.sw));
    end
  endtask

  task automatic spurious(input int id);
    n_cmp++;
    n_bad++;
    $display("FAIL dut%0d spurious_out_valid actual=1 required=0 (t=%0t)", id, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && ir[0]) cap0 = cyc + 1;
      if (ov[0]) begin
        if (q0.size() == 0) spurious(0);
        else begin
          cmp_out(0, q0[0], !vis0, cyc - cap0);
          vis0 = 1;
          if (out_ready) begin
            void'(q0.pop_front());
            vis0 = 0;
          end
        end
      end
    end else vis0 = 0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && ir[1]) cap1 = cyc + 1;
      if (ov[1]) begin
        if (q1.size() == 0) spurious(1);
        else begin
          cmp_out(1, q1[0], !vis1, cyc - cap1);
          vis1 = 1;
          if (out_ready) begin
            void'(q1.pop_front());
            vis1 = 0;
          end
        end
      end
    end else vis1 = 0;
  end

  function automatic exp_t mk(input logic sb, input logic ss, input logic [7:0] e, input logic [23:0] mb,
                              input logic [26:0] ms, input logic sw, input logic nan, input logic inf,
                              input logic data);
    exp_t r;
    r.sb = sb; r.ss = ss; r.e = e; r.mb = mb; r.ms = ms;
    r.sw = sw; r.nan = nan; r.inf = inf; r.data = data; r.lat = 0;
    return r;
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!(ir[0] && ir[1]) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk(0, "timeout_in_ready", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic op, input exp_t e,
                       input int d, input bit stall);
    exp_t e1, e4;
    int   t;
    e1 = e; e1.lat = 1 + d;
    e4 = e; e4.lat = 1 + (d + 3) / 4;
    wait_ready();
    @(posedge clk); #1;
    if (stall) out_ready = 1'b0;
    a = ia; b = ib; checkequation = op; in_valid = 1'b1;
    q0.push_back(e1);
    q1.push_back(e4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (stall) begin
      t = 0;
      while (!(ov[0] && ov[1]) && t < 100) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 100) chk(0, "timeout_stall_valid", 32'd0, 32'd1);
      repeat (5) @(posedge clk);
      #1 out_ready = 1'b1;
    end
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) begin
      chk(0, "timeout_result", 32'(q0.size() + q1.size()), 32'd0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic check_zero();
    for (int i = 0; i < 2; i++) begin
      chk(i, "rst_in_ready", 32'(ir[i]), 32'd0);
      chk(i, "rst_out_valid", 32'(ov[i]), 32'd0);
      chk(i, "rst_fields", {osb[i], oss[i], osw[i], onan[i], oinf[i], oe[i]}, 32'd0);
      chk(i, "rst_mant_big", 32'(omb[i]), 32'd0);
      chk(i, "rst_mant_small", 32'(oms[i]), 32'd0);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) chk(i, "in_ready_before_edge", 32'(ir[i]), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) chk(i, "in_ready_after_edge", 32'(ir[i]), 32'd1);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    #1 check_zero();
    release_reset();

    issue(32'h3F000000, 32'h3F000000, 1'b0, mk(0, 0, 8'h7E, 24'h800000, 27'h4000000, 0, 0, 0, 1), 0, 0);
    issue(32'h3F800000, 32'h40400000, 1'b0, mk(0, 0, 8'h80, 24'hC00000, 27'h2000000, 1, 0, 0, 1), 1, 0);
    issue(32'h3F800000, 32'h40400000, 1'b1, mk(1, 0, 8'h80, 24'hC00000, 27'h2000000, 1, 0, 0, 1), 1, 0);
    issue(32'h40000000, 32'hBF800000, 1'b1, mk(0, 0, 8'h80, 24'h800000, 27'h2000000, 0, 0, 0, 1), 1, 0);
    issue(32'h4B800000, 32'h3F800001, 1'b0, mk(0, 0, 8'h97, 24'h800000, 27'h0000005, 0, 0, 0, 1), 24, 0);
    issue(32'h4F000000, 32'h3F800000, 1'b0, mk(0, 0, 8'h9E, 24'h800000, 27'h0000001, 0, 0, 0, 1), 27, 0);
    issue(32'h00800000, 32'h00400000, 1'b0, mk(0, 0, 8'h01, 24'h800000, 27'h2000000, 0, 0, 0, 1), 0, 0);
    issue(32'h7F800000, 32'h7F800000, 1'b1, mk(0, 0, 8'h00, 24'h0, 27'h0, 0, 1, 0, 0), 0, 0);
    issue(32'h7F800000, 32'h7F800000, 1'b0, mk(0, 0, 8'h00, 24'h0, 27'h0, 0, 0, 1, 0), 0, 0);
    issue(32'h7FC00000, 32'h3F800000, 1'b0, mk(0, 0, 8'h00, 24'h0, 27'h0, 0, 1, 0, 0), 0, 0);
    // Five stalled cycles in DONE: the monitor re-checks every field and in_ready each cycle.
    issue(32'h3F800000, 32'h40400000, 1'b0, mk(0, 0, 8'h80, 24'hC00000, 27'h2000000, 1, 0, 0, 1), 1, 1);

    // Abort a d=20 operation mid-SHIFT; no result may appear afterwards.
    wait_ready();
    @(posedge clk); #1;
    a = 32'h49800000; b = 32'h3F800000; checkequation = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero();
    release_reset();
    repeat (40) @(posedge clk);

    issue(32'h3FC00000, 32'h3F400000, 1'b0, mk(0, 0, 8'h7F, 24'hC00000, 27'h3000000, 0, 0, 0, 1), 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation_time actual=expired required=finished");
    $fatal(1, "watchdog");
  end

endmodule
